// File: rtl/hack_io_ports_if.sv
// Hack CPU data-memory bus as seen by a memory-mapped peripheral.
// The CPU side (master) drives address, write data and the commit strobe;
// the peripheral (slave) returns read data and the window hit flag.
interface hack_io_ports_if #(
    parameter int ADDRESS_WIDTH = 15,
    parameter int WORD_WIDTH    = 16
);
    logic                     hack_clk_strobe;
    logic [ADDRESS_WIDTH-1:0] hack_addressM;
    logic                     hack_writeM;
    logic [WORD_WIDTH-1:0]    hack_outM;
    logic [WORD_WIDTH-1:0]    hack_inM;
    logic                     io_hit;

    modport master (
        output hack_clk_strobe,
        output hack_addressM,
        output hack_writeM,
        output hack_outM,
        input  hack_inM,
        input  io_hit
    );

    modport slave (
        input  hack_clk_strobe,
        input  hack_addressM,
        input  hack_writeM,
        input  hack_outM,
        output hack_inM,
        output io_hit
    );
endinterface

// File: rtl/hack_io_ports.sv
// Memory-mapped I/O block for a Hack CPU: keyboard keycode FIFO, status and
// interrupt-enable registers, and NUM_GPIO pairs of GPIO output/input ports
// with change detection. Register map (offset from BASE_ADDRESS):
//   0 KBD_DATA, 1 STATUS, 2 IRQ_EN, 3+2k GPIO_O[k], 4+2k GPIO_I[k].
module hack_io_ports #(
    parameter int WORD_WIDTH     = 16,
    parameter int ADDRESS_WIDTH  = 15,
    parameter int BASE_ADDRESS   = 24576,
    parameter int NUM_GPIO       = 2,
    parameter int GPIO_WIDTH     = 16,
    parameter int KBD_FIFO_DEPTH = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    hack_io_ports_if.slave                 bus,
    input  logic [7:0]                     keycode,
    input  logic                           keycode_valid,
    input  logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_i,
    output logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_o,
    output logic                           irq
);

    localparam int PTR_W  = $clog2(KBD_FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int GW     = NUM_GPIO * GPIO_WIDTH;
    localparam int WINDOW = 3 + 2 * NUM_GPIO;

    localparam logic [ADDRESS_WIDTH-1:0] BASE_A   = ADDRESS_WIDTH'(BASE_ADDRESS);
    localparam logic [ADDRESS_WIDTH-1:0] WIN_A    = ADDRESS_WIDTH'(WINDOW);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_KBD  = ADDRESS_WIDTH'(0);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_STAT = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_IREN = ADDRESS_WIDTH'(2);
    localparam logic [CNT_W-1:0]         FULL_CNT = CNT_W'(KBD_FIFO_DEPTH);

    // address decode
    logic [ADDRESS_WIDTH-1:0] offset;
    logic                     hit;
    logic                     cpu_wr;
    logic                     kbd_wr;
    logic                     status_wr;
    logic                     irqen_wr;

    // keycode FIFO
    logic [7:0]       fifo_mem [KBD_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             do_push;
    logic             do_pop;
    logic             push_drop;

    // status / control state
    logic                overflow_q;
    logic [NUM_GPIO-1:0] change_q;
    logic [NUM_GPIO-1:0] change_set;
    logic [NUM_GPIO-1:0] change_clr;
    logic [NUM_GPIO:0]   irq_en_q;
    logic [NUM_GPIO:0]   irq_src;

    // GPIO
    logic [GW-1:0] sync_q [SYNC_STAGES];
    logic [GW-1:0] gpio_sync;
    logic [GW-1:0] prev_q;
    logic [GW-1:0] gpio_o_q;

    logic [WORD_WIDTH-1:0] rdata;
    logic                  unused_outm;

    assign offset    = bus.hack_addressM - BASE_A;
    assign hit       = (bus.hack_addressM >= BASE_A) && (offset < WIN_A);
    assign bus.io_hit = hit;

    assign cpu_wr    = bus.hack_clk_strobe & bus.hack_writeM & hit;
    assign kbd_wr    = cpu_wr && (offset == OFF_KBD);
    assign status_wr = cpu_wr && (offset == OFF_STAT);
    assign irqen_wr  = cpu_wr && (offset == OFF_IREN);

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign do_pop     = kbd_wr & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push    = keycode_valid & (~fifo_full | do_pop);
    assign push_drop  = keycode_valid & fifo_full & ~do_pop;

    assign gpio_sync = sync_q[SYNC_STAGES-1];
    assign irq_src   = {change_q, ~fifo_empty};
    assign gpio_o    = gpio_o_q;

    assign unused_outm = ^bus.hack_outM;

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only visible through the pointers, so no reset
    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr] <= keycode;
    end

    // GPIO input synchroniser chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // per-port change detection and flag clear requests
    always_comb begin
        change_set = '0;
        change_clr = '0;
        for (int unsigned k = 0; k < NUM_GPIO; k++) begin
            change_set[k] = |(gpio_sync[k*GPIO_WIDTH +: GPIO_WIDTH] ^ prev_q[k*GPIO_WIDTH +: GPIO_WIDTH]);
            change_clr[k] = status_wr & bus.hack_outM[2+k];
        end
    end

    // sticky status flags; a same-cycle set wins over a CPU clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            change_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= gpio_sync;
            change_q   <= change_set | (change_q & ~change_clr);
            overflow_q <= push_drop | (overflow_q & ~(status_wr & bus.hack_outM[1]));
        end
    end

    // CPU-writable control registers: IRQ_EN and GPIO outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= '0;
            gpio_o_q <= '0;
        end else begin
            if (irqen_wr) irq_en_q <= bus.hack_outM[NUM_GPIO:0];
            for (int unsigned k = 0; k < NUM_GPIO; k++) begin
                if (cpu_wr && (offset == ADDRESS_WIDTH'(3 + 2*k)))
                    gpio_o_q[k*GPIO_WIDTH +: GPIO_WIDTH] <= bus.hack_outM[GPIO_WIDTH-1:0];
            end
        end
    end

    // interrupt level, one cycle behind the enabled sources
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= |(irq_src & irq_en_q);
    end

    // read data mux
    always_comb begin
        rdata = '0;
        if (hit) begin
            if (offset == OFF_KBD && !fifo_empty) rdata[7:0] = fifo_mem[rd_ptr];
            if (offset == OFF_STAT) begin
                rdata[0]            = ~fifo_empty;
                rdata[1]            = overflow_q;
                rdata[2 +: NUM_GPIO] = change_q;
            end
            if (offset == OFF_IREN) rdata[NUM_GPIO:0] = irq_en_q;
            for (int unsigned k = 0; k < NUM_GPIO; k++) begin
                if (offset == ADDRESS_WIDTH'(3 + 2*k))
                    rdata[GPIO_WIDTH-1:0] = gpio_o_q[k*GPIO_WIDTH +: GPIO_WIDTH];
                if (offset == ADDRESS_WIDTH'(4 + 2*k))
                    rdata[GPIO_WIDTH-1:0] = gpio_sync[k*GPIO_WIDTH +: GPIO_WIDTH];
            end
        end
    end

    assign bus.hack_inM = rdata;

endmodule

// File: tb/tb_hack_io_ports.sv
// Directed bench for hack_io_ports with default parameters
// (BASE 0x6000, 2 GPIO ports of 16 bits, 4-entry FIFO, 2 sync stages).
module tb_hack_io_ports;

    localparam int AW   = 15;
    localparam int WW   = 16;
    localparam int NG   = 2;
    localparam int GWD  = 16;
    localparam int GW   = NG * GWD;
    localparam int BASE = 24576;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    keycode;
    logic          keycode_valid;
    logic [GW-1:0] gpio_i;
    logic [GW-1:0] gpio_o;
    logic          irq;

    int checks = 0;
    int errors = 0;

    hack_io_ports_if #(.ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

    hack_io_ports #(
        .WORD_WIDTH    (WW),
        .ADDRESS_WIDTH (AW),
        .BASE_ADDRESS  (BASE),
        .NUM_GPIO      (NG),
        .GPIO_WIDTH    (GWD),
        .KBD_FIFO_DEPTH(4),
        .SYNC_STAGES   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .keycode      (keycode),
        .keycode_valid(keycode_valid),
        .gpio_i       (gpio_i),
        .gpio_o       (gpio_o),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    typedef enum int {K_PUSH, K_WR, K_WRNS, K_RD, K_PP, K_GPO, K_HIT} kind_e;

    typedef struct {
        kind_e       kind;
        int unsigned off;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(kind_e k, int unsigned off, logic [31:0] d, logic [31:0] e, string n);
        vec_t v;
        v.kind = k; v.off = off; v.data = d; v.exp = e; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input int unsigned off, input logic [15:0] data, input logic strobe);
        @(negedge clk);
        bus.hack_addressM   = AW'(BASE + off);
        bus.hack_outM       = data;
        bus.hack_writeM     = 1'b1;
        bus.hack_clk_strobe = strobe;
        @(negedge clk);
        bus.hack_writeM     = 1'b0;
        bus.hack_clk_strobe = 1'b0;
    endtask

    // combinational read at the current time, no clock wait
    task automatic peek(input string name, input int unsigned off, input logic [15:0] exp);
        bus.hack_addressM = AW'(BASE + off);
        bus.hack_writeM   = 1'b0;
        #1;
        check(name, 32'(bus.hack_inM), 32'(exp));
    endtask

    task automatic read_check(input string name, input int unsigned off, input logic [15:0] exp);
        @(negedge clk);
        peek(name, off, exp);
    endtask

    task automatic push(input logic [7:0] code);
        @(negedge clk);
        keycode       = code;
        keycode_valid = 1'b1;
        @(negedge clk);
        keycode_valid = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] code);
        @(negedge clk);
        keycode             = code;
        keycode_valid       = 1'b1;
        bus.hack_addressM   = AW'(BASE);
        bus.hack_outM       = 16'h0000;
        bus.hack_writeM     = 1'b1;
        bus.hack_clk_strobe = 1'b1;
        @(negedge clk);
        keycode_valid       = 1'b0;
        bus.hack_writeM     = 1'b0;
        bus.hack_clk_strobe = 1'b0;
    endtask

    initial begin
        reset               = 1'b1;
        keycode             = 8'h00;
        keycode_valid       = 1'b0;
        gpio_i              = '0;
        bus.hack_clk_strobe = 1'b0;
        bus.hack_addressM   = '0;
        bus.hack_writeM     = 1'b0;
        bus.hack_outM       = '0;

        // reset state
        add(K_RD,  1, 0, 0, "status_reset");
        add(K_RD,  0, 0, 0, "kbd_reset");
        add(K_RD,  2, 0, 0, "irqen_reset");
        add(K_GPO, 0, 0, 0, "gpio_o_reset");
        // window decode
        add(K_HIT, 0, 32'h5FFF, 0, "hit_below");
        add(K_HIT, 0, 32'h6000, 1, "hit_base");
        add(K_HIT, 0, 32'h6006, 1, "hit_top");
        add(K_HIT, 0, 32'h6007, 0, "hit_above");
        // basic push / pop
        add(K_PUSH, 0, 32'h41, 0, "");
        add(K_PUSH, 0, 32'h42, 0, "");
        add(K_RD,   0, 0, 32'h0041, "kbd_head1");
        add(K_RD,   1, 0, 32'h0001, "status_nonempty");
        add(K_WR,   0, 0, 0, "");
        add(K_RD,   0, 0, 32'h0042, "kbd_head2");
        add(K_WR,   0, 32'hFFFF, 0, "");
        add(K_RD,   0, 0, 0, "kbd_empty");
        add(K_RD,   1, 0, 0, "status_empty");
        add(K_WR,   0, 0, 0, "");
        add(K_RD,   1, 0, 0, "status_pop_empty");
        add(K_PUSH, 0, 32'h55, 0, "");
        add(K_RD,   0, 0, 32'h0055, "kbd_after_empty_pop");
        add(K_WR,   0, 0, 0, "");
        // overflow
        add(K_PUSH, 0, 32'h01, 0, "");
        add(K_PUSH, 0, 32'h02, 0, "");
        add(K_PUSH, 0, 32'h03, 0, "");
        add(K_PUSH, 0, 32'h04, 0, "");
        add(K_PUSH, 0, 32'h05, 0, "");
        add(K_RD,   1, 0, 32'h0003, "status_overflow");
        add(K_RD,   0, 0, 32'h0001, "kbd_ovf_head");
        add(K_WR,   1, 32'h0001, 0, "");
        add(K_RD,   1, 0, 32'h0003, "status_bit0_ignored");
        add(K_WR,   1, 32'h0002, 0, "");
        add(K_RD,   1, 0, 32'h0001, "status_ovf_cleared");
        // push and pop on a full FIFO
        add(K_PP,   0, 32'h06, 0, "");
        add(K_RD,   1, 0, 32'h0001, "status_pp_full");
        add(K_RD,   0, 0, 32'h0002, "kbd_pp_head");
        add(K_WR,   0, 0, 0, "");
        add(K_RD,   0, 0, 32'h0003, "kbd_pp_e2");
        add(K_WR,   0, 0, 0, "");
        add(K_RD,   0, 0, 32'h0004, "kbd_pp_e3");
        add(K_WR,   0, 0, 0, "");
        add(K_RD,   0, 0, 32'h0006, "kbd_pp_e4");
        add(K_WR,   0, 0, 0, "");
        add(K_RD,   1, 0, 0, "status_pp_drained");
        // GPIO outputs and strobe qualification
        add(K_WRNS, 5, 32'hBEEF, 0, "");
        add(K_GPO,  0, 0, 0, "gpio_o_nostrobe");
        add(K_RD,   5, 0, 0, "gpo1_nostrobe");
        add(K_WR,   3, 32'h1234, 0, "");
        add(K_WR,   5, 32'hBEEF, 0, "");
        add(K_GPO,  0, 0, 32'hBEEF_1234, "gpio_o_written");
        add(K_RD,   5, 0, 32'hBEEF, "gpo1_read");
        add(K_RD,   3, 0, 32'h1234, "gpo0_read");
        add(K_WRNS, 3, 32'hFFFF, 0, "");
        add(K_GPO,  0, 0, 32'hBEEF_1234, "gpio_o_nostrobe2");
        add(K_WR,   6, 32'hFFFF, 0, "");
        add(K_RD,   6, 0, 0, "gpio_i_readonly");
        // IRQ_EN
        add(K_WR,   2, 32'hFFFF, 0, "");
        add(K_RD,   2, 0, 32'h0007, "irqen_mask");
        add(K_WR,   2, 32'h0000, 0, "");
        add(K_RD,   2, 0, 0, "irqen_clear");

        repeat (2) @(negedge clk);
        check("irq_in_reset", 32'(irq), 0);
        check("gpio_o_in_reset", gpio_o, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            case (vecs[i].kind)
                K_PUSH: push(vecs[i].data[7:0]);
                K_WR:   cpu_write(vecs[i].off, vecs[i].data[15:0], 1'b1);
                K_WRNS: cpu_write(vecs[i].off, vecs[i].data[15:0], 1'b0);
                K_RD:   read_check(vecs[i].name, vecs[i].off, vecs[i].exp[15:0]);
                K_PP:   push_pop(vecs[i].data[7:0]);
                K_GPO: begin
                    @(negedge clk);
                    check(vecs[i].name, gpio_o, vecs[i].exp);
                end
                K_HIT: begin
                    @(negedge clk);
                    bus.hack_addressM = vecs[i].data[AW-1:0];
                    #1;
                    check(vecs[i].name, 32'(bus.io_hit), vecs[i].exp);
                end
                default: ;
            endcase
        end

        // change detection on port 0 bit 3 with its interrupt enabled
        cpu_write(2, 16'h0002, 1'b1);
        @(negedge clk);
        gpio_i[3] = 1'b1;
        @(negedge clk);
        peek("gpio_i_1edge", 4, 16'h0000);
        @(negedge clk);
        peek("gpio_i_2edge", 4, 16'h0008);
        peek("status_2edge", 1, 16'h0000);
        @(negedge clk);
        peek("status_3edge", 1, 16'h0004);
        check("irq_3edge", 32'(irq), 0);
        @(negedge clk);
        check("irq_4edge", 32'(irq), 1);
        cpu_write(1, 16'h0004, 1'b1);
        peek("status_chg_cleared", 1, 16'h0000);
        @(negedge clk);
        check("irq_cleared", 32'(irq), 0);

        // a clear committed on the same edge the flag sets must lose
        @(negedge clk);
        gpio_i[3] = 1'b0;
        @(negedge clk);
        cpu_write(1, 16'h0004, 1'b1);
        peek("status_set_wins", 1, 16'h0004);
        @(negedge clk);
        check("irq_after_set_wins", 32'(irq), 1);
        cpu_write(1, 16'h0004, 1'b1);
        cpu_write(2, 16'h0000, 1'b1);
        peek("status_cleared2", 1, 16'h0000);

        // asynchronous reset mid-operation
        push(8'h10);
        push(8'h11);
        push(8'h12);
        cpu_write(2, 16'h0001, 1'b1);
        @(negedge clk);
        check("irq_fifo_src", 32'(irq), 1);
        gpio_i = 32'h00FF_0000;
        peek("kbd_before_reset", 0, 16'h0010);
        #2;
        reset = 1'b1;
        #1;
        check("gpio_o_async_reset", gpio_o, 0);
        check("irq_async_reset", 32'(irq), 0);
        check("kbd_async_reset", 32'(bus.hack_inM), 0);
        @(negedge clk);
        reset = 1'b0;
        peek("status_after_reset", 1, 16'h0000);
        peek("kbd_after_reset", 0, 16'h0000);
        peek("irqen_after_reset", 2, 16'h0000);
        cpu_write(3, 16'h00AA, 1'b1);
        check("gpio_o_first_commit", gpio_o, 32'h0000_00AA);
        peek("status_2_after_release", 1, 16'h0000);
        @(negedge clk);
        peek("status_3_after_release", 1, 16'h0008);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
